// File: rtl/mem_responder.sv
// mem_responder
//   Unified instruction/data memory responder for the multi-cycle RISC-V core.
//   It accepts one fetch, load or store at a time. After LATENCY wait states it
//   returns a one-cycle response. Stores use funct3-driven byte-lane enables.
//   Loads are sign- or zero-extended.
//
//   Optional feature macro: MEM_MISALIGN_CHECK_EN
//     defined   : misaligned half/word accesses respond with rsp_err.
//     undefined : low address bits below the access size are forced to zero,
//                 and the access goes ahead.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array
//   LATENCY     : wait-state cycles between acceptance and response (0..7)
//
// Ports
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-high reset of FSM and outputs
//   req_valid : request present
//   req_ready : responder can accept (IDLE only)
//   req_we    : 1 = store, 0 = load/fetch
//   req_addr  : byte address
//   req_wdata : right-aligned store data
//   req_size  : RISC-V funct3
//   rsp_valid : one-cycle response pulse
//   rsp_rdata : extended load data, 0 for stores and errors
//   rsp_err   : bad size, out of range or misaligned (with rsp_valid)
//   busy      : responder not idle
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] LAST_CNT = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic        hold_we_q, hold_we_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [2:0]  hold_size_q, hold_size_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word_q;

    logic        accept;
    logic        enter_resp;

    // Decode source: live request while idle (needed when LATENCY==0), holding
    // registers afterwards.
    logic        src_we;
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic [2:0]  src_size;

    logic        size_ok;
    logic        in_range;
    logic        src_err;
    logic [1:0]  lane_mask;
    logic [1:0]  lane;
    logic [3:0]  base_be;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [IDX_W-1:0] idx;

    // Select the addressed lane of a word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  ln,
                                                input logic [2:0]  sz);
        logic [31:0] sh;
        sh = word >> {ln, 3'b000};
        case (sz)
            3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
            3'b010:  load_extend = sh;
            3'b100:  load_extend = {24'd0, sh[7:0]};
            3'b101:  load_extend = {16'd0, sh[15:0]};
            default: load_extend = 32'd0;
        endcase
    endfunction

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    assign accept = req_valid && req_ready;

    always_comb begin
        src_we    = hold_we_q;
        src_addr  = hold_addr_q;
        src_wdata = hold_wdata_q;
        src_size  = hold_size_q;
        if (state_q == S_IDLE) begin
            src_we    = req_we;
            src_addr  = req_addr;
            src_wdata = req_wdata;
            src_size  = req_size;
        end
    end

    always_comb begin
        in_range = ({2'b00, src_addr[31:2]} < 32'(DEPTH_WORDS));

        // lane_mask keeps the address bits that are legal for the access size.
        case (src_size[1:0])
            2'b00:   begin base_be = 4'b0001; lane_mask = 2'b11; end
            2'b01:   begin base_be = 4'b0011; lane_mask = 2'b10; end
            2'b10:   begin base_be = 4'b1111; lane_mask = 2'b00; end
            default: begin base_be = 4'b0000; lane_mask = 2'b00; end
        endcase

        if (src_we) begin
            size_ok = (src_size == 3'b000) || (src_size == 3'b001) ||
                      (src_size == 3'b010);
        end else begin
            size_ok = (src_size == 3'b000) || (src_size == 3'b001) ||
                      (src_size == 3'b010) || (src_size == 3'b100) ||
                      (src_size == 3'b101);
        end

`ifdef MEM_MISALIGN_CHECK_EN
        lane    = src_addr[1:0];
        src_err = !size_ok || !in_range || ((src_addr[1:0] & ~lane_mask) != 2'b00);
`else
        lane    = src_addr[1:0] & lane_mask;
        src_err = !size_ok || !in_range;
`endif

        be         = base_be << lane;
        wdata_lane = src_wdata << {lane, 3'b000};
        idx        = src_addr[IDX_W+1:2];
    end

    assign enter_resp = ((state_q == S_IDLE) && accept && (LATENCY == 0)) ||
                        ((state_q == S_WAIT) && (wait_cnt_q == LAST_CNT));

    // The store commits and the read word is captured on the edge into RESP.
    // The array has no reset. An aborted transaction never reaches this edge.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            if (src_we && !src_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                    end
                end
            end
            rd_word_q <= mem[idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        hold_we_d    = hold_we_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_size_d  = hold_size_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = 32'd0;
        rsp_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_we_d    = req_we;
                    hold_addr_d  = req_addr;
                    hold_wdata_d = req_wdata;
                    hold_size_d  = req_size;
                    wait_cnt_d   = 3'd0;
                    state_d      = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = src_err;
                if (!src_we && !src_err) begin
                    rsp_rdata_d = load_extend(rd_word_q, lane, src_size);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_we_q    <= hold_we_d;
        hold_addr_q  <= hold_addr_d;
        hold_wdata_q <= hold_wdata_d;
        hold_size_q  <= hold_size_d;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (DEPTH_WORDS=1024, LATENCY=2).
// Honours MEM_MISALIGN_CHECK_EN in its expectations.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_size = 3'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Byte-level reference image of the low 128 bytes of the array.
    logic [7:0] mb [0:127];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] size,
                                  output logic err, output logic [31:0] rdata);
        int nb;
        int a;
        logic [31:0] v;
        err   = 1'b0;
        rdata = 32'd0;
        case (size)
            3'b000, 3'b100: nb = 1;
            3'b001, 3'b101: nb = 2;
            3'b010:         nb = 4;
            default:        nb = 0;
        endcase
        if (nb == 0 || (we && size[2])) err = 1'b1;
        if (addr / 4 >= DEPTH) err = 1'b1;
        a = int'(addr);
        if (nb != 0) begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (a % nb != 0) err = 1'b1;
`else
            a = a - (a % nb);
`endif
        end
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mb[a+i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(mb[a+i]) << (8*i));
            if (!size[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            rdata = v;
        end
    endfunction

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        model(we, addr, wdata, size, exp_err, exp_rdata);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        @(posedge clk);
        #1;
        // Scramble request fields so stale holding data would be caught.
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_size  = 3'($urandom);
        @(negedge clk);
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(LAT + 1));
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        @(negedge clk);
        chk({tag, ".pulse"}, {30'd0, rsp_valid, rsp_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        we_r;
        logic [2:0]  sz_r;
        logic [31:0] ad_r;
        logic        seen;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err",   32'(rsp_err), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.ready", 32'(req_ready), 32'd1);

        // Fill words 0..31 with known data
        for (int w = 0; w < 32; w++) begin
            xact("fill", 1'b1, 32'(4*w), $urandom, 3'b010, rd, er);
        end

        // Word store / load round trip
        xact("t1.sw", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er);
        xact("t1.lw", 1'b0, 32'h10, 32'h0, 3'b010, rd, er);
        chk("t1.val", rd, 32'hDEADBEEF);

        // Sign / zero extension
        xact("t2.sw", 1'b1, 32'h20, 32'h000080F0, 3'b010, rd, er);
        xact("t2.lb", 1'b0, 32'h20, 32'h0, 3'b000, rd, er);
        chk("t2.lbv", rd, 32'hFFFFFFF0);
        xact("t2.lbu", 1'b0, 32'h21, 32'h0, 3'b100, rd, er);
        chk("t2.lbuv", rd, 32'h00000080);
        xact("t2.lh", 1'b0, 32'h20, 32'h0, 3'b001, rd, er);
        chk("t2.lhv", rd, 32'hFFFF80F0);
        xact("t2.lhu", 1'b0, 32'h20, 32'h0, 3'b101, rd, er);
        chk("t2.lhuv", rd, 32'h000080F0);

        // Partial stores
        xact("t3.sw", 1'b1, 32'h30, 32'h11223344, 3'b010, rd, er);
        xact("t3.sb", 1'b1, 32'h32, 32'h000000AA, 3'b000, rd, er);
        xact("t3.lw1", 1'b0, 32'h30, 32'h0, 3'b010, rd, er);
        chk("t3.v1", rd, 32'h11AA3344);
        xact("t3.sh", 1'b1, 32'h30, 32'h0000BEEF, 3'b001, rd, er);
        xact("t3.lw2", 1'b0, 32'h30, 32'h0, 3'b010, rd, er);
        chk("t3.v2", rd, 32'h11AABEEF);

        // Out of range and bad size
        xact("t4.lwoor", 1'b0, 32'(4*DEPTH), 32'h0, 3'b010, rd, er);
        chk("t4.oorerr", 32'(er), 32'd1);
        chk("t4.oorv", rd, 32'd0);
        xact("t4.swoor", 1'b1, 32'(4*DEPTH), 32'h55555555, 3'b010, rd, er);
        chk("t4.swerr", 32'(er), 32'd1);
        xact("t4.lw0", 1'b0, 32'h0, 32'h0, 3'b010, rd, er);
        xact("t4.bad", 1'b0, 32'h0, 32'h0, 3'b011, rd, er);
        chk("t4.baderr", 32'(er), 32'd1);

        // Misaligned word load
        xact("t5.sw", 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, rd, er);
        xact("t5.lw", 1'b0, 32'h41, 32'h0, 3'b010, rd, er);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("t5.err", 32'(er), 32'd1);
        chk("t5.v", rd, 32'd0);
`else
        chk("t5.err", 32'(er), 32'd0);
        chk("t5.v", rd, 32'hCAFEF00D);
`endif

        // Reset during a pending store: model is left untouched
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'h12345678;
        req_size  = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t6.valid", 32'(rsp_valid), 32'd0);
        chk("t6.rdata", rsp_rdata, 32'd0);
        chk("t6.err",   32'(rsp_err), 32'd0);
        chk("t6.busy",  32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6.ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("t6.norsp", 32'(seen), 32'd0);
        xact("t6.lw", 1'b0, 32'h50, 32'h0, 3'b010, rd, er);

        // Randomized traffic against the byte model
        for (int k = 0; k < 60; k++) begin
            we_r = 1'($urandom);
            sz_r = 3'($urandom);
            if ($urandom_range(0, 7) == 0) ad_r = 32'(4*DEPTH) + 32'($urandom_range(0, 63));
            else                           ad_r = 32'($urandom_range(0, 127));
            xact("rnd", we_r, ad_r, $urandom, sz_r, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
